// File: rtl/kalman_pkg.sv
// kalman_pkg: shared defaults, FSM state type and width helpers for the gain divider
package kalman_pkg;
  localparam int KG_DATA_W = 23;
  localparam int KG_FRAC_W = 13;
  localparam int KG_GAIN_W = 13;
  localparam int KG_N_CH = 2;
  typedef enum logic [1:0] {IDLE, DIV, STORE, DONE} kg_state_t;
  function automatic int kg_q_w(input int dw, input int fw);
    return dw + fw;
  endfunction
  function automatic int kg_cnt_w(input int dw, input int fw);
    return $clog2(dw + fw + 1);
  endfunction
endpackage

// File: rtl/kalman_div_step.sv
// kalman_div_step: one radix-2 restoring division iteration
module kalman_div_step #(
  parameter int DATA_W = 23
) (
  input  logic [DATA_W:0]   rem,
  input  logic              dmsb,
  input  logic [DATA_W-1:0] div,
  output logic [DATA_W:0]   rem_nxt,
  output logic              qbit
);
  logic [DATA_W:0] t;
  always_comb begin
    t = {rem[DATA_W-1:0], dmsb};
    qbit = rem[DATA_W] | (t >= {1'b0, div});
    rem_nxt = qbit ? t - {1'b0, div} : t;
  end
endmodule

// File: rtl/kalman_gain_div.sv
// kalman_gain_div: time-multiplexed saturating Kalman gain divider K[i] = floor(P[i]*2^FRAC_W / S)
module kalman_gain_div
  import kalman_pkg::*;
#(
  parameter int DATA_W = KG_DATA_W,
  parameter int FRAC_W = KG_FRAC_W,
  parameter int GAIN_W = KG_GAIN_W,
  parameter int N_CH = KG_N_CH
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        s_in,
  input  logic [N_CH*DATA_W-1:0]   p_in,
  output logic                     busy,
  output logic                     done,
  output logic [N_CH*GAIN_W-1:0]   k_out,
  output logic [N_CH-1:0]          sat,
  output logic                     div_zero
);
  localparam int Q_W = kg_q_w(DATA_W, FRAC_W);
  localparam int CNT_W = kg_cnt_w(DATA_W, FRAC_W);
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  kg_state_t state;
  logic [CH_W-1:0] ch, ch_n;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] s_r;
  logic [N_CH*DATA_W-1:0] p_r;
  logic [Q_W-1:0] dvd, quo;
  logic [DATA_W:0] rem, rem_nxt;
  logic qbit, s_zero, q_sat;
  logic [GAIN_W-1:0] k_new;
  logic [N_CH*GAIN_W-1:0] sh_k, sh_k_nxt;
  logic [N_CH-1:0] sh_sat, sh_sat_nxt;
  kalman_div_step #(.DATA_W(DATA_W)) u_step (
    .rem(rem),
    .dmsb(dvd[Q_W-1]),
    .div(s_r),
    .rem_nxt(rem_nxt),
    .qbit(qbit)
  );
  always_comb begin
    ch_n = ch + CH_W'(1);
    s_zero = s_r == '0;
    q_sat = |quo[Q_W-1:GAIN_W];
    k_new = (s_zero || q_sat) ? '1 : quo[GAIN_W-1:0];
    sh_k_nxt = sh_k;
    sh_k_nxt[ch*GAIN_W +: GAIN_W] = k_new;
    sh_sat_nxt = sh_sat;
    sh_sat_nxt[ch] = q_sat && !s_zero;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      ch <= '0;
      cnt <= '0;
      s_r <= '0;
      p_r <= '0;
      dvd <= '0;
      quo <= '0;
      rem <= '0;
      sh_k <= '0;
      sh_sat <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      k_out <= '0;
      sat <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          s_r <= s_in;
          p_r <= p_in;
          ch <= '0;
          cnt <= '0;
          rem <= '0;
          quo <= '0;
          dvd <= {p_in[DATA_W-1:0], {FRAC_W{1'b0}}};
          busy <= 1'b1;
          state <= DIV;
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= rem_nxt;
          quo <= {quo[Q_W-2:0], qbit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(Q_W - 1)) state <= STORE;
        end
        STORE: begin
          sh_k <= sh_k_nxt;
          sh_sat <= sh_sat_nxt;
          cnt <= '0;
          rem <= '0;
          // last channel publishes straight from the next-shadow value so all outputs flip in one edge
          if (ch == CH_W'(N_CH - 1)) begin
            k_out <= sh_k_nxt;
            sat <= sh_sat_nxt;
            div_zero <= s_zero;
            done <= 1'b1;
            state <= DONE;
          end else begin
            ch <= ch_n;
            dvd <= {p_r[ch_n*DATA_W +: DATA_W], {FRAC_W{1'b0}}};
            state <= DIV;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kalman_gain_div.sv
// tb_kalman_gain_div: table-driven and scoreboarded checks of the Kalman gain divider
module tb_kalman_gain_div;
  localparam int DW = 23;
  localparam int GW = 13;
  localparam int NC = 2;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] s_in = '0;
  logic [NC*DW-1:0] p_in = '0;
  logic busy, done, div_zero;
  logic [NC*GW-1:0] k_out;
  logic [NC-1:0] sat;
  typedef struct {
    logic [22:0] s, p0, p1;
    logic [12:0] k0, k1;
    logic [1:0]  sat;
    logic        dz;
  } vec_t;
  typedef struct {
    logic [25:0] k;
    logic [1:0]  sat;
    logic        dz;
  } exp_t;
  exp_t sbq[$];
  vec_t tbl[6];
  int total = 0;
  int passed = 0;
  logic [25:0] last_k = '0;
  kalman_gain_div dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .s_in(s_in),
    .p_in(p_in),
    .busy(busy),
    .done(done),
    .k_out(k_out),
    .sat(sat),
    .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic exp_t model(input logic [22:0] s, input logic [22:0] p0, input logic [22:0] p1);
    exp_t e;
    logic [63:0] q;
    logic [22:0] p;
    e.k = '0;
    e.sat = '0;
    e.dz = (s == '0);
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? p0 : p1;
      if (s == '0) e.k[i*13 +: 13] = 13'h1fff;
      else begin
        q = ({41'b0, p} << 13) / {41'b0, s};
        if (q > 64'd8191) begin
          e.k[i*13 +: 13] = 13'h1fff;
          e.sat[i] = 1'b1;
        end else e.k[i*13 +: 13] = q[12:0];
      end
    end
    return e;
  endfunction
  // mode 0: plain run, 1: extra starts while busy, 2: reset at cycle 40
  task automatic run(input string nm, input logic [22:0] s, input logic [22:0] p0, input logic [22:0] p1,
                     input exp_t e, input int mode);
    int n, nb, stray;
    bit got;
    exp_t g;
    n = 1; nb = 0; stray = 0; got = 1'b0;
    start = 1'b1;
    s_in = s;
    p_in = {p1, p0};
    if (mode != 2) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    s_in = 23'($urandom);
    p_in = {23'($urandom), 23'($urandom)};
    while (n <= 200) begin
      if (busy) nb++;
      if (mode == 1 && n == 10) start = 1'b1;
      if (mode == 1 && n == 11) start = 1'b0;
      if (mode != 2 && n == 40) chk({nm, " hold"}, 64'(k_out), 64'(last_k));
      if (mode == 2 && n == 40) n_rst = 1'b0;
      if (mode == 2 && n == 41) begin
        n_rst = 1'b1;
        chk({nm, " rst_outs"}, 64'({busy, done, k_out, sat, div_zero}), 64'd0);
        last_k = '0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (mode == 2) chk({nm, " no_done"}, 64'(got), 64'd0);
    else begin
      chk({nm, " done_seen"}, 64'(got), 64'd1);
      if (got) begin
        chk({nm, " latency"}, 64'(n), 64'd75);
        chk({nm, " busy_len"}, 64'(nb), 64'd75);
        if (sbq.size() == 0) chk({nm, " sb_empty"}, 64'd1, 64'd0);
        else begin
          g = sbq.pop_front();
          chk({nm, " k"}, 64'(k_out), 64'(g.k));
          chk({nm, " sat"}, 64'(sat), 64'(g.sat));
          chk({nm, " div_zero"}, 64'(div_zero), 64'(g.dz));
          last_k = g.k;
        end
        if (mode == 1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " after"}, 64'({busy, done}), 64'd0);
        if (mode == 1) begin
          repeat (80) begin
            @(negedge clk);
            if (busy || done) stray++;
          end
          chk({nm, " ignored_start"}, 64'(stray), 64'd0);
        end
      end
    end
  endtask
  initial begin
    exp_t e;
    logic [22:0] s, p0, p1;
    tbl[0] = '{23'd8192, 23'd4096, 23'd8191, 13'd4096, 13'd8191, 2'b00, 1'b0};
    tbl[1] = '{23'd3, 23'd1, 23'd2, 13'd2730, 13'd5461, 2'b00, 1'b0};
    tbl[2] = '{23'd100, 23'd100, 23'd5000, 13'd8191, 13'd8191, 2'b11, 1'b0};
    tbl[3] = '{23'd8192, 23'd8192, 23'd1, 13'd8191, 13'd1, 2'b01, 1'b0};
    tbl[4] = '{23'd0, 23'd7, 23'd0, 13'd8191, 13'd8191, 2'b00, 1'b1};
    tbl[5] = '{23'h7fffff, 23'h7fffff, 23'd0, 13'd8192 - 13'd1, 13'd0, 2'b01, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({busy, done, k_out, sat, div_zero}), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      e.k = {tbl[i].k1, tbl[i].k0};
      e.sat = tbl[i].sat;
      e.dz = tbl[i].dz;
      run($sformatf("vec%0d", i), tbl[i].s, tbl[i].p0, tbl[i].p1, e, 0);
    end
    for (int i = 0; i < 4; i++) begin
      s = 23'($urandom_range(1, 8388607));
      p0 = 23'($urandom_range(0, 32'(s)));
      p1 = 23'($urandom);
      run($sformatf("rnd%0d", i), s, p0, p1, model(s, p0, p1), 0);
    end
    e.k = {13'd5461, 13'd2730};
    e.sat = 2'b00;
    e.dz = 1'b0;
    run("busy_start", 23'd3, 23'd1, 23'd2, e, 1);
    run("mid_reset", 23'd8192, 23'd4096, 23'd8191, e, 2);
    e.k = {13'd8191, 13'd4096};
    run("post_reset", 23'd8192, 23'd4096, 23'd8191, e, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
